// File: rtl/tft_pkg.sv
// rtl/tft_pkg.sv - shared constants for the TFT timing generator
//
// Purpose: pixel-source mode encoding, RGB channel widths for the two
// legal pixel formats and the default 800x480 panel timing.
// Ports: none (package).

package tft_pkg;

   // Pixel source selected by the Mode input
   typedef enum logic [1:0] {
      MODE_PASS  = 2'd0,
      MODE_SOLID = 2'd1,
      MODE_BARS  = 2'd2,
      MODE_GRID  = 2'd3
   } tft_mode_e;

   // Channel widths, RGB565
   localparam int RGB565_R_W = 5;
   localparam int RGB565_G_W = 6;
   localparam int RGB565_B_W = 5;

   // Channel widths, RGB888
   localparam int RGB888_R_W = 8;
   localparam int RGB888_G_W = 8;
   localparam int RGB888_B_W = 8;

   // Default 800x480 timing (1056 x 525 total)
   localparam int DEF_H_SYNC   = 1;
   localparam int DEF_H_BACK   = 45;
   localparam int DEF_H_ACTIVE = 800;
   localparam int DEF_H_FRONT  = 210;
   localparam int DEF_V_SYNC   = 1;
   localparam int DEF_V_BACK   = 23;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FRONT  = 21;

endpackage

// File: rtl/tft_pattern_gen.sv
// rtl/tft_pattern_gen.sv - test-pattern pixel source for modes 1-3
//
// Purpose: produces the solid, colour-bar and grid pixels. Mode 0
// (passthrough) yields zero here; the top selects data_in instead.
// Ports:
//   mode   in  tft_mode_e  latched pixel-source mode
//   solid  in  DATA_W      latched solid colour
//   x      in  4           low nibble of the active x coordinate
//   y      in  4           low nibble of the active y coordinate
//   bar    in  3           colour-bar index 0..7
//   pixel  out DATA_W      generated pixel

module tft_pattern_gen
   import tft_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  tft_mode_e         mode,
   input  logic [DATA_W-1:0] solid,
   input  logic [3:0]        x,
   input  logic [3:0]        y,
   input  logic [2:0]        bar,
   output logic [DATA_W-1:0] pixel
);

   localparam int R_W = (DATA_W == 24) ? RGB888_R_W : RGB565_R_W;
   localparam int G_W = (DATA_W == 24) ? RGB888_G_W : RGB565_G_W;
   localparam int B_W = (DATA_W == 24) ? RGB888_B_W : RGB565_B_W;

   always_comb begin
      pixel = '0;
      case (mode)
         MODE_SOLID: pixel = solid;
         // Each bar-index bit drives one whole colour channel
         MODE_BARS:  pixel = DATA_W'({{R_W{bar[2]}}, {G_W{bar[1]}}, {B_W{bar[0]}}});
         MODE_GRID:  pixel = ((x == 4'd0) || (y == 4'd0)) ? '1 : '0;
         default:    pixel = '0;
      endcase
   end

endmodule

// File: rtl/tft_timing_gen.sv
// rtl/tft_timing_gen.sv - TFT panel timing and pixel output generator
//
// Purpose: runs the horizontal/vertical raster counters, requests pixels
// during the active window, and drives registered DE/HS/VS/RGB one cycle
// after the counter state they describe.
// Ports:
//   Clk          in  1       pixel clock
//   Rst          in  1       asynchronous active-high reset
//   En           in  1       timing run enable
//   Mode         in  2       0 passthrough, 1 solid, 2 colour bars, 3 grid
//   Solid        in  DATA_W  solid colour for mode 1
//   data_in      in  DATA_W  pixel answering the current data_req
//   data_req     out 1       pixel request (combinational)
//   hcount       out CNT_W   active-relative x of the request, else 0
//   vcount       out CNT_W   active-relative y of the request, else 0
//   TFT_RGB      out DATA_W  pixel output
//   TFT_HS       out 1       line sync
//   TFT_VS       out 1       frame sync
//   TFT_DE       out 1       data enable
//   frame_start  out 1       one-cycle marker at the frame origin

module tft_timing_gen
   import tft_pkg::*;
#(
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BACK   = DEF_H_BACK,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FRONT  = DEF_H_FRONT,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BACK   = DEF_V_BACK,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FRONT  = DEF_V_FRONT,
   parameter int DATA_W   = 16,
   parameter int CNT_W    = 12,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              En,
   input  logic [1:0]        Mode,
   input  logic [DATA_W-1:0] Solid,
   input  logic [DATA_W-1:0] data_in,
   output logic              data_req,
   output logic [CNT_W-1:0]  hcount,
   output logic [CNT_W-1:0]  vcount,
   output logic [DATA_W-1:0] TFT_RGB,
   output logic              TFT_HS,
   output logic              TFT_VS,
   output logic              TFT_DE,
   output logic              frame_start
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam int BAR_W   = H_ACTIVE / 8;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_SYNC);
   localparam logic [CNT_W-1:0] H_ACT_S  = CNT_W'(H_SYNC + H_BACK);
   localparam logic [CNT_W-1:0] H_ACT_E  = CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_S  = CNT_W'(V_SYNC + V_BACK);
   localparam logic [CNT_W-1:0] V_ACT_E  = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);
   localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

   logic [CNT_W-1:0]  h_cnt;
   logic [CNT_W-1:0]  v_cnt;
   logic              h_act;
   logic              v_act;
   logic              frame_org;
   tft_mode_e         mode_lat;
   logic [DATA_W-1:0] solid_lat;
   logic [CNT_W-1:0]  bar_px;
   logic [2:0]        bar_idx;
   logic [DATA_W-1:0] pat_pix;
   logic [DATA_W-1:0] pix;

   // Raster counters; En=0 parks them at the origin so a restart is a fresh frame
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (!En) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   // Request stage
   always_comb begin
      h_act     = (h_cnt >= H_ACT_S) && (h_cnt < H_ACT_E);
      v_act     = (v_cnt >= V_ACT_S) && (v_cnt < V_ACT_E);
      data_req  = En && h_act && v_act;
      hcount    = data_req ? (h_cnt - H_ACT_S) : '0;
      vcount    = data_req ? (v_cnt - V_ACT_S) : '0;
      frame_org = (h_cnt == '0) && (v_cnt == '0);
   end

   // Mode/colour only change at the frame origin so a frame is never mixed
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         mode_lat  <= MODE_PASS;
         solid_lat <= '0;
      end else if (En && frame_org) begin
         mode_lat  <= tft_mode_e'(Mode);
         solid_lat <= Solid;
      end
   end

   // Bar index tracks the requested pixel without a divider. Bar 7 absorbs
   // any remainder pixels when H_ACTIVE is not a multiple of 8.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         bar_px  <= '0;
         bar_idx <= '0;
      end else if (!data_req) begin
         bar_px  <= '0;
         bar_idx <= '0;
      end else if ((bar_px == BAR_LAST) && (bar_idx != 3'd7)) begin
         bar_px  <= '0;
         bar_idx <= bar_idx + 3'd1;
      end else begin
         bar_px  <= bar_px + 1'b1;
      end
   end

   tft_pattern_gen #(
      .DATA_W (DATA_W)
   ) u_pattern (
      .mode  (mode_lat),
      .solid (solid_lat),
      .x     (hcount[3:0]),
      .y     (vcount[3:0]),
      .bar   (bar_idx),
      .pixel (pat_pix)
   );

   assign pix = (mode_lat == MODE_PASS) ? data_in : pat_pix;

   // Output stage, one cycle behind the counters
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         TFT_DE      <= 1'b0;
         TFT_RGB     <= '0;
         TFT_HS      <= ~HS_POL;
         TFT_VS      <= ~VS_POL;
         frame_start <= 1'b0;
      end else if (!En) begin
         TFT_DE      <= 1'b0;
         TFT_RGB     <= '0;
         TFT_HS      <= ~HS_POL;
         TFT_VS      <= ~VS_POL;
         frame_start <= 1'b0;
      end else begin
         TFT_DE      <= data_req;
         TFT_RGB     <= data_req ? pix : '0;
         TFT_HS      <= (h_cnt < H_SYNC_E) ? HS_POL : ~HS_POL;
         TFT_VS      <= (v_cnt < V_SYNC_E) ? VS_POL : ~VS_POL;
         frame_start <= frame_org;
      end
   end

endmodule

// File: tb/tb_tft_timing_gen.sv
// tb/tb_tft_timing_gen.sv - self-checking bench for tft_timing_gen

module tb_tft_timing_gen;

   localparam int HSY = 1, HBK = 3, HAC = 43, HFR = 4;
   localparam int VSY = 1, VBK = 2, VAC = 6,  VFR = 2;
   localparam int HT = HSY + HBK + HAC + HFR;
   localparam int VT = VSY + VBK + VAC + VFR;
   localparam int FRAME = HT * VT;
   localparam bit HPOL = 1'b1;
   localparam bit VPOL = 1'b0;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        En = 1'b0;
   logic [1:0]  Mode = 2'd0;
   logic [15:0] Solid = 16'h0;
   logic [15:0] data_in = 16'h0;
   logic        data_req;
   logic [11:0] hcount;
   logic [11:0] vcount;
   logic [15:0] TFT_RGB;
   logic        TFT_HS;
   logic        TFT_VS;
   logic        TFT_DE;
   logic        frame_start;

   always #5 Clk = ~Clk;

   tft_timing_gen #(
      .H_SYNC(HSY), .H_BACK(HBK), .H_ACTIVE(HAC), .H_FRONT(HFR),
      .V_SYNC(VSY), .V_BACK(VBK), .V_ACTIVE(VAC), .V_FRONT(VFR),
      .DATA_W(16), .CNT_W(12), .HS_POL(HPOL), .VS_POL(VPOL)
   ) dut (
      .Clk(Clk), .Rst(Rst), .En(En), .Mode(Mode), .Solid(Solid),
      .data_in(data_in), .data_req(data_req), .hcount(hcount),
      .vcount(vcount), .TFT_RGB(TFT_RGB), .TFT_HS(TFT_HS),
      .TFT_VS(TFT_VS), .TFT_DE(TFT_DE), .frame_start(frame_start)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: raster position as a single index into the frame
   int          pos = 0;
   int          m_mode = 0;
   logic [15:0] m_solid = 16'h0;
   logic        e_de = 1'b0;
   logic [15:0] e_rgb = 16'h0;
   logic        e_hs = ~HPOL;
   logic        e_vs = ~VPOL;
   logic        e_fs = 1'b0;
   bit          coord_data = 1'b1;

   logic [15:0] bar_colour [8] = '{16'h0000, 16'h001F, 16'h07E0, 16'h07FF,
                                   16'hF800, 16'hF81F, 16'hFFE0, 16'hFFFF};

   // Per-frame statistics from the DUT outputs
   bit have_fs = 1'b0;
   int st_cyc = 0, st_de = 0, st_hs = 0, st_vsl = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit in_active(input int p);
      int h, v;
      h = p % HT;
      v = p / HT;
      return (h >= HSY + HBK) && (h < HSY + HBK + HAC) &&
             (v >= VSY + VBK) && (v < VSY + VBK + VAC);
   endfunction

   function automatic logic [15:0] expected_pixel(input int mode, input logic [15:0] sol,
                                                  input logic [15:0] din, input int x, input int y);
      int b;
      case (mode)
         0: return din;
         1: return sol;
         2: begin
            b = x / (HAC / 8);
            if (b > 7) b = 7;
            return bar_colour[b];
         end
         default: return ((x % 16 == 0) || (y % 16 == 0)) ? 16'hFFFF : 16'h0000;
      endcase
   endfunction

   task automatic model_reset();
      pos = 0;
      m_mode = 0;
      m_solid = 16'h0;
      e_de = 1'b0; e_rgb = 16'h0; e_hs = ~HPOL; e_vs = ~VPOL; e_fs = 1'b0;
   endtask

   task automatic check_outputs();
      bit act;
      act = En && !Rst && in_active(pos);
      chk("data_req", 32'(data_req), 32'(act));
      chk("hcount", 32'(hcount), act ? 32'(pos % HT - (HSY + HBK)) : 32'd0);
      chk("vcount", 32'(vcount), act ? 32'(pos / HT - (VSY + VBK)) : 32'd0);
      chk("TFT_DE", 32'(TFT_DE), 32'(e_de));
      chk("TFT_RGB", 32'(TFT_RGB), 32'(e_rgb));
      chk("TFT_HS", 32'(TFT_HS), 32'(e_hs));
      chk("TFT_VS", 32'(TFT_VS), 32'(e_vs));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
      if (Rst || !En) have_fs = 1'b0;
      if (frame_start === 1'b1) begin
         if (have_fs) begin
            chk("frame_period", 32'(st_cyc), 32'(FRAME));
            chk("de_per_frame", 32'(st_de), 32'(HAC * VAC));
            chk("hs_act_per_frame", 32'(st_hs), 32'(HSY * VT));
            chk("vs_act_per_frame", 32'(st_vsl), 32'(VSY * HT));
         end
         have_fs = 1'b1;
         st_cyc = 0; st_de = 0; st_hs = 0; st_vsl = 0;
      end
      st_cyc++;
      if (TFT_DE === 1'b1) st_de++;
      if (TFT_HS === HPOL) st_hs++;
      if (TFT_VS === VPOL) st_vsl++;
   endtask

   task automatic advance_model();
      int h, v;
      bit act;
      if (Rst) begin
         model_reset();
      end else if (!En) begin
         pos = 0;
         e_de = 1'b0; e_rgb = 16'h0; e_hs = ~HPOL; e_vs = ~VPOL; e_fs = 1'b0;
      end else begin
         h = pos % HT;
         v = pos / HT;
         act = in_active(pos);
         e_de = act;
         e_rgb = act ? expected_pixel(m_mode, m_solid, data_in, h - (HSY + HBK), v - (VSY + VBK)) : 16'h0;
         e_hs = (h < HSY) ? HPOL : ~HPOL;
         e_vs = (v < VSY) ? VPOL : ~VPOL;
         e_fs = (pos == 0);
         if (pos == 0) begin
            m_mode = int'(Mode);
            m_solid = Solid;
         end
         pos = (pos + 1) % FRAME;
      end
   endtask

   task automatic tick();
      if (coord_data) begin
         if (En && in_active(pos))
            data_in = {8'(pos / HT - (VSY + VBK)), 8'(pos % HT - (HSY + HBK))};
         else
            data_in = 16'h0;
      end
      @(negedge Clk);
      check_outputs();
      advance_model();
      @(posedge Clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic run_to_line(input int line);
      for (int i = 0; i < FRAME && (pos / HT) != line; i++) tick();
   endtask

   int off_cnt = 0;

   initial begin
      // Reset state
      run(3);
      Rst = 1'b0;
      En = 1'b1;

      // Mode 0 with coordinate data, including the frame-period statistics
      run(2 * FRAME + 10);

      // Colour bars, then grid (changes land at the next frame)
      Mode = 2'd2;
      run(2 * FRAME);
      Mode = 2'd3;
      run(2 * FRAME);

      // Mode 0 -> 1 mid-frame at line 4
      Mode = 2'd0;
      run(FRAME);
      run_to_line(4);
      Mode = 2'd1;
      Solid = 16'hF800;
      run(2 * FRAME);

      // En low for 10 cycles mid-line
      run_to_line(5);
      run(20);
      En = 1'b0;
      run(10);
      En = 1'b1;
      run(2 * FRAME + 5);

      // Rst pulsed mid-frame: idle outputs are visible before the next edge
      run_to_line(6);
      run(7);
      Rst = 1'b1;
      model_reset();
      run(2);
      Rst = 1'b0;
      run(2 * FRAME + 5);

      // Randomized operation with sporadic En drops and reset pulses
      coord_data = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (Rst) begin
            Rst = 1'b0;
         end else if ($urandom_range(0, 699) == 0) begin
            Rst = 1'b1;
            model_reset();
         end
         if (off_cnt > 0) begin
            off_cnt--;
            En = 1'b0;
         end else begin
            En = 1'b1;
            if ($urandom_range(0, 299) == 0) off_cnt = $urandom_range(1, 12);
         end
         if ($urandom_range(0, 49) == 0) Mode = 2'($urandom_range(0, 3));
         Solid = 16'($urandom);
         data_in = 16'($urandom);
         tick();
      end
      Rst = 1'b0;
      En = 1'b1;
      run(FRAME + 5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
